pir_display_scan: RTL and testbench



---
 rtl/pir_display_scan.sv | 212 +++++++++++++++++++++
 tb/tb_pir_display_scan.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pir_display_scan.sv
// Display-side consumer of the motion controller status word: latches the word, converts
// its 8-bit fields to BCD with a shift-add-3 engine and scans an 8-digit active-low display.
module pir_display_scan #(
  parameter int SCAN_DIV    = 1000,
  parameter int PAGE_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display_data,
  output logic [6:0]  seg_n,
  output logic [7:0]  an_n,
  output logic        busy
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_C     = 7'h46;

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t r_state, w_state_nxt;

  // Conversion engine
  logic [31:0] r_shadow;
  logic [7:0]  r_bin_pk, r_bin_ls, r_bin_ct;
  logic [11:0] r_bcd_pk, r_bcd_ls, r_bcd_ct;
  logic [3:0]  r_iter;
  logic        r_busy;

  // Committed display image
  logic [11:0] r_dsp_pk, r_dsp_ls, r_dsp_ct;
  logic [3:0]  r_id_pk, r_id_ls;

  // Scan
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [FRM_W-1:0] r_frame, w_frame_nxt;
  logic             r_page, w_page_nxt;
  logic             w_div_term, w_frame_wrap, w_frm_term;
  logic [6:0]       r_seg_n, w_seg_nxt;
  logic [7:0]       r_an_n, w_an_nxt;

  logic        w_start, w_commit;
  logic [19:0] w_step_pk, w_step_ls, w_step_ct;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  // Values 10..15 only ever reach this through an id field, where they render as 'E'.
  function automatic logic [6:0] num_seg(input logic [3:0] d);
    case (d)
      4'd0:    num_seg = 7'h40;
      4'd1:    num_seg = 7'h79;
      4'd2:    num_seg = 7'h24;
      4'd3:    num_seg = 7'h30;
      4'd4:    num_seg = 7'h19;
      4'd5:    num_seg = 7'h12;
      4'd6:    num_seg = 7'h02;
      4'd7:    num_seg = 7'h78;
      4'd8:    num_seg = 7'h00;
      4'd9:    num_seg = 7'h10;
      default: num_seg = SEG_E;
    endcase
  endfunction

  function automatic logic [6:0] id_seg(input logic [3:0] id);
    id_seg = (id == 4'd0) ? SEG_DASH : num_seg(id);
  endfunction

  function automatic logic [6:0] val_seg(input logic [11:0] bcd, input logic [1:0] pos);
    logic h_zero, t_zero;
    h_zero = (bcd[11:8] == 4'd0);
    t_zero = (bcd[7:4] == 4'd0);
    case (pos)
      2'd2:    val_seg = h_zero ? SEG_BLANK : num_seg(bcd[11:8]);
      2'd1:    val_seg = (h_zero && t_zero) ? SEG_BLANK : num_seg(bcd[7:4]);
      default: val_seg = num_seg(bcd[3:0]);
    endcase
  endfunction

  assign w_start  = (r_state == S_IDLE) && (display_data != r_shadow);
  assign w_commit = (r_state == S_CONVERT) && (r_iter == 4'd8);

  assign w_step_pk = {add3(r_bcd_pk), r_bin_pk} << 1;
  assign w_step_ls = {add3(r_bcd_ls), r_bin_ls} << 1;
  assign w_step_ct = {add3(r_bcd_ct), r_bin_ct} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal assigned in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_start)  w_state_nxt = S_CONVERT;
      S_CONVERT: if (w_commit) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_bin_pk <= '0;
      r_bin_ls <= '0;
      r_bin_ct <= '0;
      r_bcd_pk <= '0;
      r_bcd_ls <= '0;
      r_bcd_ct <= '0;
      r_iter   <= '0;
      r_busy   <= 1'b0;
      r_dsp_pk <= '0;
      r_dsp_ls <= '0;
      r_dsp_ct <= '0;
      r_id_pk  <= '0;
      r_id_ls  <= '0;
    end else if (w_start) begin
      r_shadow <= display_data;
      r_bin_pk <= display_data[7:0];
      r_bin_ls <= display_data[19:12];
      r_bin_ct <= display_data[31:24];
      r_bcd_pk <= '0;
      r_bcd_ls <= '0;
      r_bcd_ct <= '0;
      r_iter   <= '0;
      r_busy   <= 1'b1;
    end else if (w_commit) begin
      // Ids come from the same shadow sample as the converted values.
      r_dsp_pk <= r_bcd_pk;
      r_dsp_ls <= r_bcd_ls;
      r_dsp_ct <= r_bcd_ct;
      r_id_pk  <= r_shadow[11:8];
      r_id_ls  <= r_shadow[23:20];
      r_busy   <= 1'b0;
    end else if (r_state == S_CONVERT) begin
      {r_bcd_pk, r_bin_pk} <= w_step_pk;
      {r_bcd_ls, r_bin_ls} <= w_step_ls;
      {r_bcd_ct, r_bin_ct} <= w_step_ct;
      r_iter <= r_iter + 4'd1;
    end
  end

  assign w_div_term   = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_div_nxt    = w_div_term ? '0 : r_div + 1'b1;
  assign w_idx_nxt    = w_div_term ? r_idx + 3'd1 : r_idx;
  assign w_frame_wrap = w_div_term && (r_idx == 3'd7);
  assign w_frm_term   = (r_frame == FRM_W'(PAGE_FRAMES - 1));
  assign w_frame_nxt  = w_frame_wrap ? (w_frm_term ? '0 : r_frame + 1'b1) : r_frame;
  assign w_page_nxt   = (w_frame_wrap && w_frm_term) ? ~r_page : r_page;

  // Digit enables are blanked for the first clock of every slot to hide segment transitions.
  assign w_an_nxt = (w_div_nxt == '0) ? 8'hFF : ~(8'd1 << w_idx_nxt);

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    if (!w_page_nxt) begin
      case (w_idx_nxt)
        3'd7:    w_seg_nxt = id_seg(r_id_pk);
        3'd6:    w_seg_nxt = val_seg(r_dsp_pk, 2'd2);
        3'd5:    w_seg_nxt = val_seg(r_dsp_pk, 2'd1);
        3'd4:    w_seg_nxt = val_seg(r_dsp_pk, 2'd0);
        3'd3:    w_seg_nxt = id_seg(r_id_ls);
        3'd2:    w_seg_nxt = val_seg(r_dsp_ls, 2'd2);
        3'd1:    w_seg_nxt = val_seg(r_dsp_ls, 2'd1);
        default: w_seg_nxt = val_seg(r_dsp_ls, 2'd0);
      endcase
    end else begin
      case (w_idx_nxt)
        3'd7:    w_seg_nxt = SEG_C;
        3'd2:    w_seg_nxt = val_seg(r_dsp_ct, 2'd2);
        3'd1:    w_seg_nxt = val_seg(r_dsp_ct, 2'd1);
        3'd0:    w_seg_nxt = val_seg(r_dsp_ct, 2'd0);
        default: w_seg_nxt = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_idx   <= '0;
      r_frame <= '0;
      r_page  <= 1'b0;
      r_seg_n <= SEG_BLANK;
      r_an_n  <= 8'hFF;
    end else begin
      r_div   <= w_div_nxt;
      r_idx   <= w_idx_nxt;
      r_frame <= w_frame_nxt;
      r_page  <= w_page_nxt;
      r_seg_n <= w_seg_nxt;
      r_an_n  <= w_an_nxt;
    end
  end

  assign seg_n = r_seg_n;
  assign an_n  = r_an_n;
  assign busy  = r_busy;

endmodule

// File: tb/tb_pir_display_scan.sv
// Directed bench for pir_display_scan with SCAN_DIV=4, PAGE_FRAMES=2 (32-clock frames,
// page toggles every 64 clocks); expected segment patterns are hand-computed constants.
module tb_pir_display_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] display_data = '0;
  logic [6:0]  seg_n;
  logic [7:0]  an_n;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc;
  int an_err, seg_err, hi, hi2, rises, rises2;
  logic [6:0] got [8];

  pir_display_scan #(.SCAN_DIV(4), .PAGE_FRAMES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .display_data (display_data),
    .seg_n        (seg_n),
    .an_n         (an_n),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; slot/digit/page timing is derived from this.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic busy_window(input int n, output int n_hi, output int n_rise);
    logic prev;
    prev   = busy;
    n_hi   = 0;
    n_rise = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (busy === 1'b1) n_hi++;
      if (busy === 1'b1 && prev !== 1'b1) n_rise++;
      prev = busy;
    end
  endtask

  // Captures one full frame of the requested page, checking an_n every clock.
  task automatic capture(input string tag, input int want_page, input logic [55:0] exp);
    int guard, k, idx;
    logic [7:0] exp_an;
    guard   = 0;
    an_err  = 0;
    seg_err = 0;
    for (int i = 0; i < 8; i++) got[i] = 'x;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!(((cyc % 32) == 1) && (((cyc / 64) % 2) == want_page)) && guard < 400);
    check({tag, " sync"}, 64'(guard < 400), 64'd1);
    for (int s = 0; s < 31; s++) begin
      if (s > 0) begin
        @(posedge clk); #1;
      end
      k      = cyc;
      idx    = (k / 4) % 8;
      exp_an = ((k % 4) == 0) ? 8'hFF : ~(8'd1 << idx);
      if (an_n !== exp_an) an_err++;
      if ((k % 4) == 1) got[idx] = seg_n;
      else if ((k % 4) != 0 && seg_n !== got[idx]) seg_err++;
    end
    check({tag, " an_n scan"}, 64'(an_err), 64'd0);
    check({tag, " seg stable"}, 64'(seg_err), 64'd0);
    check({tag, " digits"}, {8'h0, got[7], got[6], got[5], got[4], got[3], got[2], got[1], got[0]},
          {8'h0, exp});
  endtask

  initial begin
    // 1: reset state, zero input never converts
    repeat (3) @(posedge clk);
    #1;
    check("reset an_n", 64'(an_n), 64'hFF);
    check("reset seg_n", 64'(seg_n), 64'h7F);
    check("reset busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    busy_window(20, hi, rises);
    check("zero input busy", 64'(hi), 64'd0);
    capture("zero p0", 0, {7'h3F, 7'h7F, 7'h7F, 7'h40, 7'h3F, 7'h7F, 7'h7F, 7'h40});

    // 2: count=5, last id 2, last 73, peak id 3, peak 120
    display_data = {8'd5, 4'd2, 8'd73, 4'd3, 8'd120};
    @(posedge clk); #1;
    check("t2 busy rise", 64'(busy), 64'd1);
    busy_window(14, hi, rises);
    check("t2 busy rest", 64'(hi), 64'd8);
    check("t2 busy single", 64'(rises), 64'd0);
    capture("t2 p0", 0, {7'h30, 7'h79, 7'h24, 7'h40, 7'h24, 7'h7F, 7'h78, 7'h30});

    // 3: page toggling
    capture("t3 p1", 1, {7'h46, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    capture("t3 p0 again", 0, {7'h30, 7'h79, 7'h24, 7'h40, 7'h24, 7'h7F, 7'h78, 7'h30});

    // 4: change during conversion is picked up right after commit
    display_data = {8'd5, 4'd2, 8'd73, 4'd3, 8'd255};
    busy_window(3, hi, rises);
    display_data = {8'd5, 4'd2, 8'd73, 4'd3, 8'd9};
    busy_window(25, hi2, rises2);
    check("t4 busy cycles", 64'(hi + hi2), 64'd18);
    check("t4 busy pulses", 64'(rises + rises2), 64'd2);
    capture("t4 p0", 0, {7'h30, 7'h7F, 7'h7F, 7'h10, 7'h24, 7'h7F, 7'h78, 7'h30});

    // 5: peak 255 id 12 ('E'), last 100 id 0 ('-'), count 200
    display_data = {8'd200, 4'd0, 8'd100, 4'd12, 8'd255};
    busy_window(15, hi, rises);
    check("t5 busy cycles", 64'(hi), 64'd9);
    capture("t5 p0", 0, {7'h06, 7'h24, 7'h12, 7'h12, 7'h3F, 7'h79, 7'h40, 7'h40});
    capture("t5 p1", 1, {7'h46, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h40, 7'h40});

    // 6: reset mid-conversion, then reconvert the unchanged input
    display_data = {8'd42, 4'd7, 8'd8, 4'd1, 8'd64};
    busy_window(4, hi, rises);
    check("t6 busy before reset", 64'(hi), 64'd4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async an_n", 64'(an_n), 64'hFF);
    check("t6 async seg_n", 64'(seg_n), 64'h7F);
    check("t6 async busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6 reconvert rise", 64'(busy), 64'd1);
    busy_window(14, hi, rises);
    check("t6 reconvert rest", 64'(hi), 64'd8);
    capture("t6 p0", 0, {7'h79, 7'h7F, 7'h02, 7'h19, 7'h78, 7'h7F, 7'h7F, 7'h00});
    capture("t6 p1", 1, {7'h46, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
